// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Definitions shared by the streaming CNN units (pool, upsample, conv) so that
// every stage agrees on pixel width, default image size and counter sizing.
//
// Contents:
//   DATA_W      pixel width in bits (signed)
//   DEF_IMG_W   default full-resolution image width
//   DEF_IMG_H   default full-resolution image height
//   pixel_t     signed pixel type
//   clog2()     ceil(log2(n)), never less than 1, so that counters for tiny
//               images still get a legal 1-bit width
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int DATA_W    = 8;
    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;

    typedef logic signed [DATA_W-1:0] pixel_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/line_buffer_1r1w.sv
// -----------------------------------------------------------------------------
// line_buffer_1r1w
// Single line of pixel storage with one synchronous write port and one
// asynchronous (combinational) read port. Used by the upsampler to replay the
// even output row as the following odd row; the max-pool stage can reuse it
// to hold partial row results.
//
// Ports:
//   clk       input         write clock, rising edge
//   i_we      input         write enable
//   i_waddr   input  AW     write address
//   i_wdata   input  DW     write data
//   i_raddr   input  AW     read address
//   o_rdata   output DW     read data, valid in the same cycle as i_raddr
// -----------------------------------------------------------------------------
module line_buffer_1r1w #(
    parameter int DEPTH = 14,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    // Contents are don't-care after reset, so the storage carries no reset
    // and maps onto distributed RAM.
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/upsample_2x_unit.sv
// -----------------------------------------------------------------------------
// upsample_2x_unit
// Streaming 2x nearest-neighbour upsampler. A row-major (IMG_W/2)x(IMG_H/2)
// signed feature map enters one pixel per handshake; an IMG_W x IMG_H stream
// leaves in which every input pixel fills a 2x2 block.
//
// Even output rows (ROW_A) come straight from the input: each accepted pixel
// is emitted twice and also stored in a line buffer. Odd output rows (ROW_B)
// replay the line buffer without consuming input and without bubbles.
//
// Parameters:
//   IMG_W   output image width  (even, >= 4)
//   IMG_H   output image height (even, >= 2)
//
// Ports:
//   clk         input         sole clock, rising edge
//   rst_n       input         asynchronous active-low reset
//   in_valid    input         upstream pixel available
//   in_ready    output        pixel accepted this cycle if in_valid; depends
//                             on state only
//   in_data     input  8s     input pixel, row-major
//   out_valid   output        out_data valid (registered)
//   out_data    output 8s     output pixel, row-major (registered)
//   frame_done  output        pulse with the last output pixel of a frame
// -----------------------------------------------------------------------------
module upsample_2x_unit
    import cnn_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     frame_done
);

    localparam int CW = clog2(IMG_W);
    localparam int RW = clog2(IMG_H);
    // Column counter drops its LSB to index the half-width line buffer;
    // for an even width this is exactly clog2(IMG_W/2) bits.
    localparam int AW = CW - 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {
        ROW_A = 1'b0,
        ROW_B = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [CW-1:0]   r_col_cnt;
    logic [RW-1:0]   r_row_cnt;
    logic            r_dup;
    logic            r_out_valid;
    pixel_t          r_out_data;
    logic            r_frame_done;

    state_t          w_state_next;
    logic [CW-1:0]   w_col_next;
    logic [RW-1:0]   w_row_next;
    logic            w_dup_next;
    logic            w_out_valid_next;
    pixel_t          w_out_data_next;
    logic            w_frame_done_next;

    logic            w_col_last;
    logic            w_row_last;
    logic            w_buf_we;
    logic [AW-1:0]   w_buf_addr;
    logic [DATA_W-1:0] w_buf_rdata;

    assign w_col_last = (r_col_cnt == COL_LAST);
    assign w_row_last = (r_row_cnt == ROW_LAST);

    // Both the store in ROW_A and the replay in ROW_B use column/2, so a
    // single address serves the write and the read port.
    assign w_buf_addr = r_col_cnt[CW-1:1];

    // A pending duplicate blocks input; in_valid never feeds back here.
    assign in_ready = (r_state == ROW_A) && !r_dup;

    // ------------------------------------------------------------------
    // Line buffer
    // ------------------------------------------------------------------
    line_buffer_1r1w #(
        .DEPTH (IMG_W / 2),
        .AW    (AW),
        .DW    (DATA_W)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (w_buf_addr),
        .i_wdata (in_data),
        .i_raddr (w_buf_addr),
        .o_rdata (w_buf_rdata)
    );

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_col_next        = r_col_cnt;
        w_row_next        = r_row_cnt;
        w_dup_next        = r_dup;
        w_out_valid_next  = 1'b0;
        w_out_data_next   = r_out_data;
        w_frame_done_next = 1'b0;
        w_buf_we          = 1'b0;

        case (r_state)
            ROW_A: begin
                if (r_dup) begin
                    // Second copy: always emitted, even if upstream has
                    // dropped in_valid. out_data is simply held.
                    w_out_valid_next = 1'b1;
                    w_dup_next       = 1'b0;
                    if (w_col_last) begin
                        w_col_next   = '0;
                        w_row_next   = r_row_cnt + RW'(1);
                        w_state_next = ROW_B;
                    end else begin
                        w_col_next = r_col_cnt + CW'(1);
                    end
                end else if (in_valid) begin
                    w_out_valid_next = 1'b1;
                    w_out_data_next  = in_data;
                    w_buf_we         = 1'b1;
                    w_col_next       = r_col_cnt + CW'(1);
                    w_dup_next       = 1'b1;
                end
                // Otherwise: upstream bubble, nothing advances.
            end

            ROW_B: begin
                w_out_valid_next = 1'b1;
                w_out_data_next  = pixel_t'(w_buf_rdata);
                if (w_col_last) begin
                    w_col_next   = '0;
                    w_state_next = ROW_A;
                    if (w_row_last) begin
                        w_row_next        = '0;
                        w_frame_done_next = 1'b1;
                    end else begin
                        w_row_next = r_row_cnt + RW'(1);
                    end
                end else begin
                    w_col_next = r_col_cnt + CW'(1);
                end
            end

            default: begin
                w_state_next = ROW_A;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ROW_A;
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_dup        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_col_cnt    <= w_col_next;
            r_row_cnt    <= w_row_next;
            r_dup        <= w_dup_next;
            r_out_valid  <= w_out_valid_next;
            r_out_data   <= w_out_data_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_upsample_2x_unit.sv
// -----------------------------------------------------------------------------
// tb_upsample_2x_unit
// Self-checking bench for upsample_2x_unit. A 28x28 instance is driven with
// ramp, signed-extreme and random-stall frames and compared against a
// reference built directly from out[R][C] = in[R/2][C/2]. An 8x4 instance is
// checked cycle by cycle from a fixed vector table.
// -----------------------------------------------------------------------------
module tb_upsample_2x_unit;

    localparam int W     = 28;
    localparam int H     = 28;
    localparam int FR    = W * H;
    localparam int IW    = W / 2;
    localparam int IH    = H / 2;
    localparam int IN_FR = IW * IH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 28x28 instance
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic              frame_done;

    // 8x4 instance
    logic              s_rst_n;
    logic              s_in_valid;
    logic              s_in_ready;
    logic signed [7:0] s_in_data;
    logic              s_out_valid;
    logic signed [7:0] s_out_data;
    logic              s_frame_done;

    upsample_2x_unit #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    upsample_2x_unit #(.IMG_W(8), .IMG_H(4)) dut_s (
        .clk        (clk),
        .rst_n      (s_rst_n),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .out_valid  (s_out_valid),
        .out_data   (s_out_data),
        .frame_done (s_frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Ready exactly at even columns of even output rows, counted from the
    // number of outputs already produced in the frame.
    function automatic bit ready_exp(input int idx);
        int p;
        p = idx % FR;
        return (((p / W) % 2) == 0) && (((p % W) % 2) == 0);
    endfunction

    // ------------------------------------------------------------------
    // 8x4 vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       vld;
        logic [7:0] din;
        logic       rdy;
        logic [7:0] dout;
        logic       fd;
    } vec_t;

    int din_l [32] = '{1,99,2,99,3,99,4,99, 99,99,99,99,99,99,99,99,
                       5,99,6,99,7,99,8,99, 99,99,99,99,99,99,99,99};
    int rdy_l [32] = '{1,0,1,0,1,0,1,0, 0,0,0,0,0,0,0,0,
                       1,0,1,0,1,0,1,0, 0,0,0,0,0,0,0,0};
    int dout_l[32] = '{1,1,2,2,3,3,4,4, 1,1,2,2,3,3,4,4,
                       5,5,6,6,7,7,8,8, 5,5,6,6,7,7,8,8};
    vec_t tbl [32];

    // ------------------------------------------------------------------
    // 28x28 stream runner
    // mode 0: ramp r*14+c-98, mode 1: -128/127 alternating, mode 2: random
    // abort_at >= 0: reset asserted right after that output index appears
    // ------------------------------------------------------------------
    logic signed [7:0] in_q [$];
    logic signed [7:0] exp_q [$];

    task automatic run_main(input int nframes, input int mode, input int duty,
                            input int abort_at);
        int  out_idx;
        int  in_ptr;
        int  fd_cnt;
        int  cyc;
        int  budget;
        bit  prev_rdy;
        bit  prev_acc;
        bit  done;
        bit  aborted;
        logic signed [7:0] v;

        in_q.delete();
        exp_q.delete();
        for (int f = 0; f < nframes; f++) begin
            for (int k = 0; k < IN_FR; k++) begin
                case (mode)
                    0:       v = 8'((k / IW) * IW + (k % IW) - 98);
                    1:       v = (k % 2 == 0) ? -8'sd128 : 8'sd127;
                    default: v = 8'($urandom);
                endcase
                in_q.push_back(v);
            end
        end
        for (int f = 0; f < nframes; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    exp_q.push_back(in_q[f * IN_FR + (r / 2) * IW + (c / 2)]);

        out_idx  = 0;
        in_ptr   = 0;
        fd_cnt   = 0;
        cyc      = 0;
        budget   = nframes * FR * 4 + 200;
        prev_rdy = 1'b1;
        prev_acc = 1'b0;
        done     = 1'b0;
        aborted  = 1'b0;

        while (!done) begin
            @(negedge clk);
            cyc++;
            chk("out_valid", out_valid, (!prev_rdy || prev_acc));
            if (out_valid) begin
                if (out_idx < exp_q.size())
                    chk("out_data", out_data, exp_q[out_idx]);
                chk("frame_done", frame_done, ((out_idx % FR) == FR - 1));
                if (frame_done) fd_cnt++;
                out_idx++;
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
            chk("in_ready", in_ready, ready_exp(out_idx));

            if (abort_at >= 0 && out_idx == abort_at + 1) begin
                aborted = 1'b1;
                done    = 1'b1;
            end else if (out_idx >= exp_q.size()) begin
                done = 1'b1;
            end else if (cyc > budget) begin
                errors++;
                $display("FAIL timeout outputs=%0d required=%0d", out_idx, exp_q.size());
                done = 1'b1;
            end else begin
                if (in_ready) begin
                    in_valid = ($urandom_range(0, 99) < duty) && (in_ptr < in_q.size());
                    in_data  = in_valid ? in_q[in_ptr] : 8'($urandom);
                end else begin
                    // Valid junk while not ready must never be consumed.
                    in_valid = 1'b1;
                    in_data  = 8'($urandom);
                end
                prev_rdy = ready_exp(out_idx);
                prev_acc = in_valid && in_ready;
                if (prev_acc) in_ptr++;
            end
        end
        in_valid = 1'b0;

        if (aborted) begin
            rst_n = 1'b0;
            #1;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("abort_frame_done_count", fd_cnt, 0);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            chk("out_count", out_idx, nframes * FR);
            chk("frame_done_count", fd_cnt, nframes);
            chk("in_consumed", in_ptr, nframes * IN_FR);
        end
        $display("run mode=%0d frames=%0d duty=%0d outputs=%0d cycles=%0d",
                 mode, nframes, duty, out_idx, cyc);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            tbl[i].vld  = 1'b1;
            tbl[i].din  = 8'(din_l[i]);
            tbl[i].rdy  = rdy_l[i][0];
            tbl[i].dout = 8'(dout_l[i]);
            tbl[i].fd   = (i == 31);
        end

        rst_n      = 1'b0;
        s_rst_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        s_in_valid = 1'b0;
        s_in_data  = '0;

        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_frame_done", frame_done, 0);
        rst_n   = 1'b1;
        s_rst_n = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_s_in_ready", s_in_ready, 1);

        // 8x4 table, in_valid held high
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("s_out_valid", s_out_valid, 1);
                chk("s_out_data", s_out_data, tbl[i-1].dout);
                chk("s_frame_done", s_frame_done, tbl[i-1].fd);
                $display("small idx=%0d out=%0d fd=%0d", i - 1, s_out_data, s_frame_done);
            end
            if (i < 32) begin
                chk("s_in_ready", s_in_ready, tbl[i].rdy);
                s_in_valid = tbl[i].vld;
                s_in_data  = tbl[i].din;
            end else begin
                chk("s_in_ready_wrap", s_in_ready, 1);
                s_in_valid = 1'b0;
            end
        end

        run_main(1, 0, 100, -1);   // ramp, no stalls
        run_main(1, 1, 100, -1);   // signed extremes
        run_main(2, 2, 50, -1);    // random data, 50% upstream duty
        run_main(1, 0, 100, 300);  // reset mid-frame
        run_main(1, 0, 100, -1);   // fresh frame after reset

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
